// File: rtl/pipelined_core_param.sv
// Parametrised 4-stage (IF/ID/EX/WB) integer core with EX/WB forwarding, RF write-through,
// ID-resolved jumps, EX-resolved conditional branches, a global stall and retire/debug ports.
module pipelined_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int NREG   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic [15:0]       ImemData,
    input  logic              Stall,
    output logic              WbValid,
    output logic [3:0]        WbRd,
    output logic [DATA_W-1:0] WbData,
    output logic [15:0]       Retired,
    input  logic [3:0]        DbgSel,
    output logic [DATA_W-1:0] DbgData
);
    localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_LI   = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_BEQZ = 4'd9;

    function automatic logic [ADDR_W-1:0] sext_addr(input logic [7:0] v);
        return ADDR_W'($signed(v));
    endfunction

    function automatic logic [DATA_W-1:0] sext_data(input logic [7:0] v);
        return DATA_W'($signed(v));
    endfunction

    // Architectural state
    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] rf_reg [NREG];
    logic [15:0]       retired_reg;

    // IF/ID
    logic              ifid_valid_reg;
    logic [15:0]       ifid_instr_reg;
    logic [ADDR_W-1:0] ifid_pc_reg;

    // ID/EX
    logic              idex_valid_reg;
    logic [3:0]        idex_op_reg;
    logic [RIW-1:0]    idex_rd_reg;
    logic [RIW-1:0]    idex_rs_reg;
    logic [DATA_W-1:0] idex_rd_val_reg;
    logic [DATA_W-1:0] idex_rs_val_reg;
    logic [7:0]        idex_imm_reg;
    logic [ADDR_W-1:0] idex_pc_reg;

    // EX/WB
    logic              exwb_valid_reg;
    logic              exwb_wr_reg;
    logic [RIW-1:0]    exwb_rd_reg;
    logic [DATA_W-1:0] exwb_data_reg;

    // Decode in ID
    logic [3:0]        id_op;
    logic [RIW-1:0]    id_rd;
    logic [RIW-1:0]    id_rs;
    logic [7:0]        id_imm;
    logic [DATA_W-1:0] id_rd_val;
    logic [DATA_W-1:0] id_rs_val;
    logic              id_jmp;
    logic [ADDR_W-1:0] id_jmp_target;

    // Execute
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_result;
    logic              ex_wr;
    logic              ex_br_taken;
    logic [ADDR_W-1:0] ex_br_target;

    logic              wb_we;
    logic [ADDR_W-1:0] pc_next;

    assign wb_we = exwb_valid_reg && exwb_wr_reg && !Stall;

    assign id_op  = ifid_instr_reg[15:12];
    assign id_rd  = ifid_instr_reg[8 +: RIW];
    assign id_rs  = ifid_instr_reg[4 +: RIW];
    assign id_imm = ifid_instr_reg[7:0];

    // Write-through: a register committed this cycle is seen by the instruction in ID.
    assign id_rd_val = (wb_we && exwb_rd_reg == id_rd) ? exwb_data_reg : rf_reg[id_rd];
    assign id_rs_val = (wb_we && exwb_rd_reg == id_rs) ? exwb_data_reg : rf_reg[id_rs];

    assign id_jmp        = ifid_valid_reg && (id_op == OP_JMP);
    assign id_jmp_target = ifid_pc_reg + sext_addr(id_imm);

    // Forward the WB result to EX whenever the older instruction writes the same register.
    assign ex_a = (exwb_valid_reg && exwb_wr_reg && exwb_rd_reg == idex_rd_reg)
                  ? exwb_data_reg : idex_rd_val_reg;
    assign ex_b = (exwb_valid_reg && exwb_wr_reg && exwb_rd_reg == idex_rs_reg)
                  ? exwb_data_reg : idex_rs_val_reg;
    assign ex_imm = sext_data(idex_imm_reg);

    always_comb begin
        ex_result = '0;
        ex_wr     = 1'b1;
        case (idex_op_reg)
            OP_ADD:  ex_result = ex_a + ex_b;
            OP_SUB:  ex_result = ex_a - ex_b;
            OP_AND:  ex_result = ex_a & ex_b;
            OP_OR:   ex_result = ex_a | ex_b;
            OP_XOR:  ex_result = ex_a ^ ex_b;
            OP_LI:   ex_result = ex_imm;
            OP_ADDI: ex_result = ex_a + ex_imm;
            default: ex_wr     = 1'b0;
        endcase
    end

    assign ex_br_taken  = idex_valid_reg && (idex_op_reg == OP_BEQZ) && (ex_a == '0);
    assign ex_br_target = idex_pc_reg + sext_addr(idex_imm_reg);

    // The older branch in EX takes priority over a jump in ID, which it squashes anyway.
    always_comb begin
        pc_next = pc_reg + ADDR_W'(1);
        if (ex_br_taken) begin
            pc_next = ex_br_target;
        end else if (id_jmp) begin
            pc_next = id_jmp_target;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_reg          <= '0;
            ifid_valid_reg  <= 1'b0;
            ifid_instr_reg  <= '0;
            ifid_pc_reg     <= '0;
            idex_valid_reg  <= 1'b0;
            idex_op_reg     <= '0;
            idex_rd_reg     <= '0;
            idex_rs_reg     <= '0;
            idex_rd_val_reg <= '0;
            idex_rs_val_reg <= '0;
            idex_imm_reg    <= '0;
            idex_pc_reg     <= '0;
            exwb_valid_reg  <= 1'b0;
            exwb_wr_reg     <= 1'b0;
            exwb_rd_reg     <= '0;
            exwb_data_reg   <= '0;
            retired_reg     <= '0;
        end else if (!Stall) begin
            pc_reg          <= pc_next;

            ifid_valid_reg  <= !(ex_br_taken || id_jmp);
            ifid_instr_reg  <= ImemData;
            ifid_pc_reg     <= pc_reg;

            idex_valid_reg  <= ifid_valid_reg && !ex_br_taken;
            idex_op_reg     <= id_op;
            idex_rd_reg     <= id_rd;
            idex_rs_reg     <= id_rs;
            idex_rd_val_reg <= id_rd_val;
            idex_rs_val_reg <= id_rs_val;
            idex_imm_reg    <= id_imm;
            idex_pc_reg     <= ifid_pc_reg;

            exwb_valid_reg  <= idex_valid_reg;
            exwb_wr_reg     <= ex_wr;
            exwb_rd_reg     <= idex_rd_reg;
            exwb_data_reg   <= ex_result;

            if (exwb_valid_reg) begin
                retired_reg <= retired_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_we && exwb_rd_reg == RIW'(i)) begin
                    rf_reg[i] <= exwb_data_reg;
                end
            end
        end
    end

    // Index fields wider than the register file are ignored.
    generate
        if (RIW < 4) begin : g_narrow_idx
            logic unused_idx_bits;
            assign unused_idx_bits = ^{DbgSel[3:RIW], ifid_instr_reg[11:8+RIW]};
        end
    endgenerate

    assign ImemAddr = pc_reg;
    assign WbValid  = exwb_valid_reg && exwb_wr_reg;
    assign WbRd     = 4'(exwb_rd_reg);
    assign WbData   = exwb_data_reg;
    assign Retired  = retired_reg;
    assign DbgData  = rf_reg[DbgSel[RIW-1:0]];

endmodule
